// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// Holds the FSM encoding, the wait-counter width and the error-cause codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int WAIT_W = 4;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RW_BOTH  = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  // Classify a request; the first matching cause wins, any non-NONE code makes the access a no-op.
  function automatic logic [1:0] err_cause(input logic rd, input logic wr,
                                           input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << (addr_w + 32'd2);
    if (rd && wr) begin
      err_cause = ERR_RW_BOTH;
    end else if (addr[1:0] != 2'b00) begin
      err_cause = ERR_MISALIGN;
    end else if ((addr & hi_mask) != 32'h0000_0000) begin
      err_cause = ERR_RANGE;
    end else begin
      err_cause = ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word RAM with a synchronous per-lane write and a registered read port.
// Contents are never reset; only the read register is.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write into the storage array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Read register only moves on a completed legal read, so it holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0000_0000;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_wait_responder.sv
// Wait-state responder for the CPU data-memory port: latches a request, counts WAIT_CYCLES,
// then pulses dm_ready (with dm_err on illegal accesses). Define DMEM_BE_EN for byte-lane writes.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        dm_cs,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
`ifdef DMEM_BE_EN
  input  logic [3:0]  dm_be,
`endif
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_err
);

  localparam int                WAIT_LOAD_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_LOAD_I[WAIT_W-1:0];

  dmem_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              write_q;
  logic [1:0]        cause_q;
  logic              ready_q;
  logic              err_q;
  logic              accept;
  logic              commit;
  logic              ram_we;
  logic              ram_re;
  logic [3:0]        be_in;

`ifdef DMEM_BE_EN
  assign be_in = dm_be;
`else
  assign be_in = 4'b1111;
`endif

  // Next-state logic; the request inputs are only looked at while IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_cs && (dm_r || dm_w)) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {WAIT_W{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, request latch and registered handshake outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {WAIT_W{1'b0}};
      idx_q   <= {ADDR_W{1'b0}};
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'b0000;
      write_q <= 1'b0;
      cause_q <= ERR_NONE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      err_q   <= commit && (cause_q != ERR_NONE);
      if (accept) begin
        idx_q   <= dm_addr[ADDR_W+1:2];
        wdata_q <= dm_wdata;
        be_q    <= be_in;
        write_q <= dm_w;
        cause_q <= err_cause(dm_r, dm_w, dm_addr, ADDR_W);
      end
    end
  end

  assign ram_we = commit && write_q && (cause_q == ERR_NONE);
  assign ram_re = commit && !write_q && (cause_q == ERR_NONE);

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk_in),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .be_i    (be_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .re_i    (ram_re),
    .rdata_o (dm_rdata)
  );

  assign dm_ready = ready_q;
  assign dm_err   = err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: directed table, multi-cycle corner sequences and a randomized
// run against a word-level memory model; a second instance covers WAIT_CYCLES=0.
module tb_dmem_wait_responder;

  localparam int DEPTH = 1024;
  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, r, w;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        ready, err;
  logic        cs1, r1, w1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1;
  logic        ready1, err1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk_in(clk), .reset(reset), .dm_cs(cs), .dm_r(r), .dm_w(w),
    .dm_addr(addr), .dm_wdata(wdata),
`ifdef DMEM_BE_EN
    .dm_be(be),
`endif
    .dm_rdata(rdata), .dm_ready(ready), .dm_err(err)
  );

  dmem_wait_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_in(clk), .reset(reset), .dm_cs(cs1), .dm_r(r1), .dm_w(w1),
    .dm_addr(addr1), .dm_wdata(wdata1),
`ifdef DMEM_BE_EN
    .dm_be(be1),
`endif
    .dm_rdata(rdata1), .dm_ready(ready1), .dm_err(err1)
  );

  // Reference model: word-indexed memory plus the last value returned by a legal read.
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] b,
                            output logic exp_err, output logic [31:0] exp_rd);
    int unsigned word;
    logic [31:0] cur;
    exp_err = (rd && wr) || (a % 4 != 0) || (a >= DEPTH * 4);
    word = a / 4;
    if (!exp_err && wr) begin
      cur = mdl_mem.exists(word) ? mdl_mem[word] : 32'h0;
`ifdef DMEM_BE_EN
      for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = wd[8*i +: 8];
`else
      cur = wd;
`endif
      mdl_mem[word] = cur;
    end else if (!exp_err && rd) begin
      mdl_rdata = mdl_mem[word];
    end
    exp_rd = mdl_rdata;
  endtask

  // One CPU access; request is withdrawn and scrambled right after the accept edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output int lat, output logic e, output logic [31:0] rv);
    bit got = 0;
    @(negedge clk);
    cs = 1'b1; r = rd; w = wr; addr = a; wdata = wd; be = b;
    @(posedge clk); #1;
    cs = 1'b0; r = 1'b0; w = 1'b0; addr = $urandom; wdata = $urandom; be = 4'($urandom);
    lat = 0; e = 1'b0; rv = 32'h0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ready) begin
        got = 1; e = err; rv = rdata;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      check("ready_one_cycle", {31'h0, ready}, 32'h0);
      check("err_without_ready", {31'h0, err}, 32'h0);
    end else begin
      lat = -1;
    end
  endtask

  task automatic run_check(input string name, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                           input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    logic e;
    logic [31:0] rv;
    access(rd, wr, a, wd, b, lat, e, rv);
    check({name, "_latency"}, 32'(lat), 32'(WAITS + 1));
    check({name, "_err"}, {31'h0, e}, {31'h0, exp_err});
    check({name, "_rdata"}, rv, exp_rd);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic        pe;
    logic [31:0] prd;
    bit          saw_ready;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0BAD, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h8000_0010, 32'h2222_2222, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h3333_3333, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0BAD_F00D};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};

    cs = 1'b0; r = 1'b0; w = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'hF;
    cs1 = 1'b0; r1 = 1'b0; w1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; be1 = 4'hF;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_rdata", rdata, 32'h0);

    for (int i = 0; i < 12; i++) begin
      model_step(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, 4'hF, pe, prd);
      run_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
                4'hF, vecs[i].exp_err, vecs[i].exp_rd);
    end

    // Reset in the middle of a write's wait: nothing completes and the old word survives.
    @(negedge clk);
    cs = 1'b1; r = 1'b0; w = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    cs = 1'b0; w = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midwait_rst_ready", {31'h0, ready}, 32'h0);
    check("midwait_rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mdl_rdata = 32'h0;
    saw_ready = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready) saw_ready = 1;
    end
    check("midwait_no_ready", {31'h0, saw_ready}, 32'h0);
    model_step(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, pe, prd);
    run_check("midwait_old", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D);

`ifdef DMEM_BE_EN
    model_step(1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'hF, pe, prd);
    run_check("be_pre", 1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'hF, 1'b0, 32'hCAFE_F00D);
    model_step(1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'b0101, pe, prd);
    run_check("be_wr", 1'b0, 1'b1, 32'h4, 32'h1122_3344, 4'b0101, 1'b0, 32'hCAFE_F00D);
    model_step(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, pe, prd);
    run_check("be_rd", 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'hAA22_CC44);
    model_step(1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, pe, prd);
    run_check("be_zero", 1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'hAA22_CC44);
    model_step(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, pe, prd);
    run_check("be_zero_rd", 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'hAA22_CC44);
`endif

    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      model_step(1'b0, 1'b1, 32'(i * 4), d, 4'hF, pe, prd);
      run_check("preload", 1'b0, 1'b1, 32'(i * 4), d, 4'hF, pe, prd);
    end

    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic        rr, ww;
      logic [31:0] a, d;
      logic [3:0]  b;
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15) * 4);
      d = $urandom;
`ifdef DMEM_BE_EN
      b = 4'($urandom);
`else
      b = 4'hF;
`endif
      rr = 1'($urandom); ww = !rr;
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = (32'($urandom_range(1, 1048575)) << 12) | a;
      else if (kind == 2) begin rr = 1'b1; ww = 1'b1; end
      model_step(rr, ww, a, d, b, pe, prd);
      run_check("rand", rr, ww, a, d, b, pe, prd);
    end

    // Zero-wait instance: accept, ready one cycle later, next accept two cycles after the first.
    @(negedge clk);
    cs1 = 1'b1; w1 = 1'b1; r1 = 1'b0; addr1 = 32'h8; wdata1 = 32'hA5A5_0001;
    @(posedge clk); #1;
    w1 = 1'b0; r1 = 1'b1;
    check("w0_ready_after_accept", {31'h0, ready1}, 32'h0);
    @(posedge clk); #1;
    check("w0_write_ready", {31'h0, ready1}, 32'h1);
    check("w0_write_err", {31'h0, err1}, 32'h0);
    @(posedge clk); #1;
    cs1 = 1'b0; r1 = 1'b0;
    check("w0_gap", {31'h0, ready1}, 32'h0);
    @(posedge clk); #1;
    check("w0_read_ready", {31'h0, ready1}, 32'h1);
    check("w0_read_rdata", rdata1, 32'hA5A5_0001);
    @(posedge clk); #1;
    check("w0_read_pulse", {31'h0, ready1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
